// File: rtl/lstm_ctrl_pkg.sv
// Shared definitions for the LSTM layer sequencers: FSM state encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lstm_ctrl_pkg;

    localparam int DEF_WIDTH    = 12;
    localparam int DEF_TIMESTEP = 7;
    localparam int DEF_INPUT    = 53;
    localparam int DEF_CELL     = 53;
    localparam int DEF_ACT_LAT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/nest_cnt.sv
// Three-level k/n/t index counter; k steps alone, n steps with carry into t.
// Latency: counts update on the clock edge; *_nxt expose the value about to be loaded.
// Backpressure: none; the caller gates the level enables.
module nest_cnt #(
    parameter int W      = 12,
    parameter int K_TERM = 52,
    parameter int N_TERM = 52,
    parameter int T_TERM = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc_k,
    input  logic         inc_n,
    output logic [W-1:0] k_nxt,
    output logic [W-1:0] n,
    output logic [W-1:0] n_nxt,
    output logic [W-1:0] t,
    output logic [W-1:0] t_nxt,
    output logic         k_wrap,
    output logic         n_wrap,
    output logic         t_wrap
);

    localparam logic [W-1:0] K_T = W'(K_TERM);
    localparam logic [W-1:0] N_T = W'(N_TERM);
    localparam logic [W-1:0] T_T = W'(T_TERM);

    logic [W-1:0] k;

    // Wrap flags: a level is at its terminal count and is being stepped (t steps only on n carry)
    always_comb begin
        k_wrap = inc_k && (k == K_T);
        n_wrap = inc_n && (n == N_T);
        t_wrap = n_wrap && (t == T_T);
    end

    // Next count for every level; clear has priority over stepping
    always_comb begin
        k_nxt = k;
        n_nxt = n;
        t_nxt = t;
        if (clr) begin
            k_nxt = '0;
            n_nxt = '0;
            t_nxt = '0;
        end else begin
            if (inc_k) begin
                k_nxt = k_wrap ? '0 : k + W'(1);
            end
            if (inc_n) begin
                n_nxt = n_wrap ? '0 : n + W'(1);
                if (n_wrap) begin
                    t_nxt = t_wrap ? '0 : t + W'(1);
                end
            end
        end
    end

    // Count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
            n <= '0;
            t <= '0;
        end else begin
            k <= k_nxt;
            n <= n_nxt;
            t <= t_nxt;
        end
    end

endmodule

// File: rtl/layer1_seq_ctrl.sv
// LSTM layer-1 sequencer: per timestep t and cell n, accumulate W*x / U*h over k, wait ACT_LAT, write h/c.
// Latency: start sampled in IDLE -> ACC on the next cycle; all outputs registered and aligned to the FSM state.
// Backpressure: none; start is only honoured in IDLE. Optional LAYR1_TS_DONE_EN adds ts_done/cur_ts.
module layer1_seq_ctrl
    import lstm_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TIMESTEP    = DEF_TIMESTEP,
    parameter int LAYR1_INPUT = DEF_INPUT,
    parameter int LAYR1_CELL  = DEF_CELL,
    parameter int ACT_LAT     = DEF_ACT_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             acc_x_1,
    output logic             acc_h_1,
    output logic [WIDTH-1:0] addr_x1,
    output logic [WIDTH-1:0] rd_addr_w_1,
    output logic [WIDTH-1:0] rd_addr_u_1,
    output logic [WIDTH-1:0] rd_addr_b_1,
    output logic [WIDTH-1:0] rd_addr_h1,
    output logic [WIDTH-1:0] rd_addr_c1,
    output logic             wr_h1,
    output logic             wr_c1,
    output logic [WIDTH-1:0] wr_addr_h1,
`ifdef LAYR1_TS_DONE_EN
    output logic             ts_done,
    output logic [WIDTH-1:0] cur_ts,
`endif
    output logic [WIDTH-1:0] wr_addr_c1
);

    localparam logic [WIDTH-1:0] IN_W   = WIDTH'(LAYR1_INPUT);
    localparam logic [WIDTH-1:0] CELL_W = WIDTH'(LAYR1_CELL);
    localparam logic [WIDTH-1:0] LAT_T  = WIDTH'(ACT_LAT - 1);

    seq_state_t state, state_d;

    logic [WIDTH-1:0] k_nxt, n_cur, n_nxt, t_cur, t_nxt;
    logic             k_wrap, n_wrap, t_wrap;
    logic             clr_cnt, inc_k, inc_n;

    logic [WIDTH-1:0] lat;
    logic             lat_last;

    // Running products kept as bases: tx=t*IN, tc=t*CELL, nw=n*IN, nu=n*CELL
    logic [WIDTH-1:0] tx_base, tc_base, nw_base, nu_base;
    logic [WIDTH-1:0] tx_base_d, tc_base_d, nw_base_d, nu_base_d;
    logic             adv_n, adv_t, clr_base;

    logic             busy_d, done_d, acc_x_d, acc_h_d, wr_d, enter_acc;
    logic [WIDTH-1:0] addr_x_d, addr_w_d, addr_u_d, addr_b_d, addr_h_d, addr_c_d, wr_addr_d;

    assign clr_cnt = (state == ST_IDLE) || (state == ST_DONE);
    assign inc_k   = (state == ST_ACC);
    assign inc_n   = (state == ST_WRITE);

    nest_cnt #(
        .W      (WIDTH),
        .K_TERM (LAYR1_INPUT - 1),
        .N_TERM (LAYR1_CELL - 1),
        .T_TERM (TIMESTEP - 1)
    ) u_nest_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_cnt),
        .inc_k  (inc_k),
        .inc_n  (inc_n),
        .k_nxt  (k_nxt),
        .n      (n_cur),
        .n_nxt  (n_nxt),
        .t      (t_cur),
        .t_nxt  (t_nxt),
        .k_wrap (k_wrap),
        .n_wrap (n_wrap),
        .t_wrap (t_wrap)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state: k wrap ends ACC, latency counter ends WAIT, t wrap in WRITE ends the run
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = ST_ACC;
            ST_ACC:   if (k_wrap) state_d = ST_WAIT;
            ST_WAIT:  if (lat_last) state_d = ST_WRITE;
            ST_WRITE: state_d = t_wrap ? ST_DONE : ST_ACC;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign lat_last = (state == ST_WAIT) && (lat == LAT_T);

    // Activation-latency counter, live only in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat <= '0;
        end else if ((state == ST_WAIT) && !lat_last) begin
            lat <= lat + WIDTH'(1);
        end else begin
            lat <= '0;
        end
    end

    // Base updates: next cell steps the n bases, next timestep steps the t bases and rewinds n
    always_comb begin
        adv_n     = (state == ST_WRITE) && !n_wrap;
        adv_t     = (state == ST_WRITE) && n_wrap && !t_wrap;
        clr_base  = (state == ST_IDLE) || (state == ST_DONE);
        tx_base_d = tx_base;
        tc_base_d = tc_base;
        nw_base_d = nw_base;
        nu_base_d = nu_base;
        if (clr_base) begin
            tx_base_d = '0;
            tc_base_d = '0;
            nw_base_d = '0;
            nu_base_d = '0;
        end else if (adv_n) begin
            nw_base_d = nw_base + IN_W;
            nu_base_d = nu_base + CELL_W;
        end else if (adv_t) begin
            tx_base_d = tx_base + IN_W;
            tc_base_d = tc_base + CELL_W;
            nw_base_d = '0;
            nu_base_d = '0;
        end
    end

    // Base registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_base <= '0;
            tc_base <= '0;
            nw_base <= '0;
            nu_base <= '0;
        end else begin
            tx_base <= tx_base_d;
            tc_base <= tc_base_d;
            nw_base <= nw_base_d;
            nu_base <= nu_base_d;
        end
    end

    // FSM outputs: decode the upcoming state so the registered outputs line up with it;
    // addresses load a base on ACC entry and then step by one, otherwise they hold
    always_comb begin
        busy_d    = (state_d == ST_ACC) || (state_d == ST_WAIT) || (state_d == ST_WRITE);
        done_d    = (state_d == ST_DONE);
        acc_x_d   = (state_d == ST_ACC);
        acc_h_d   = acc_x_d && (t_nxt != '0) && (k_nxt < CELL_W);
        wr_d      = (state_d == ST_WRITE);
        enter_acc = acc_x_d && (state != ST_ACC);
        addr_x_d  = addr_x1;
        addr_w_d  = rd_addr_w_1;
        addr_b_d  = rd_addr_b_1;
        addr_h_d  = rd_addr_h1;
        addr_u_d  = rd_addr_u_1;
        addr_c_d  = rd_addr_c1;
        wr_addr_d = wr_addr_h1;
        if (acc_x_d) begin
            if (enter_acc) begin
                addr_x_d = tx_base_d;
                addr_w_d = nw_base_d;
                addr_b_d = n_nxt;
            end else begin
                addr_x_d = addr_x1 + WIDTH'(1);
                addr_w_d = rd_addr_w_1 + WIDTH'(1);
            end
        end
        if (acc_h_d) begin
            // U*h runs k=0..CELL-1, so its first cycle is always the ACC entry
            if (enter_acc) begin
                addr_h_d = tc_base_d - CELL_W;
                addr_u_d = nu_base_d;
            end else begin
                addr_h_d = rd_addr_h1 + WIDTH'(1);
                addr_u_d = rd_addr_u_1 + WIDTH'(1);
            end
        end
        if (wr_d) begin
            wr_addr_d = tc_base + n_cur;
            addr_c_d  = (t_cur != '0) ? (tc_base - CELL_W + n_cur) : '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_x_1     <= 1'b0;
            acc_h_1     <= 1'b0;
            addr_x1     <= '0;
            rd_addr_w_1 <= '0;
            rd_addr_u_1 <= '0;
            rd_addr_b_1 <= '0;
            rd_addr_h1  <= '0;
            rd_addr_c1  <= '0;
            wr_h1       <= 1'b0;
            wr_c1       <= 1'b0;
            wr_addr_h1  <= '0;
            wr_addr_c1  <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            acc_x_1     <= acc_x_d;
            acc_h_1     <= acc_h_d;
            addr_x1     <= addr_x_d;
            rd_addr_w_1 <= addr_w_d;
            rd_addr_u_1 <= addr_u_d;
            rd_addr_b_1 <= addr_b_d;
            rd_addr_h1  <= addr_h_d;
            rd_addr_c1  <= addr_c_d;
            wr_h1       <= wr_d;
            wr_c1       <= wr_d;
            wr_addr_h1  <= wr_addr_d;
            wr_addr_c1  <= wr_addr_d;
        end
    end

`ifdef LAYR1_TS_DONE_EN
    // Timestep-complete pulse the cycle after the last cell's WRITE; cur_ts trails t by one cycle
    // so that it still names the finished timestep while ts_done is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_done <= 1'b0;
            cur_ts  <= '0;
        end else begin
            ts_done <= n_wrap;
            cur_ts  <= t_cur;
        end
    end
`endif

endmodule

// File: tb/tb_layer1_seq_ctrl.sv
// Self-checking bench for layer1_seq_ctrl: small geometry runs against a loop-built expected trace,
// plus a default-geometry single-timestep instance for the long-run busy count.
module tb_layer1_seq_ctrl;

    localparam int W    = 12;
    localparam int TS   = 2;
    localparam int IN   = 3;
    localparam int CELL = 2;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;

    always #5 clk = ~clk;

    logic         busy, done, acc_x_1, acc_h_1, wr_h1, wr_c1;
    logic [W-1:0] addr_x1, rd_addr_w_1, rd_addr_u_1, rd_addr_b_1, rd_addr_h1, rd_addr_c1;
    logic [W-1:0] wr_addr_h1, wr_addr_c1;

    logic         busy2, done2, acc_x2, acc_h2, wr_h2, wr_c2;
    logic [W-1:0] addr_x2, rd_addr_w2, rd_addr_u2, rd_addr_b2, rd_addr_h2, rd_addr_c2;
    logic [W-1:0] wr_addr_h2, wr_addr_c2;

`ifdef LAYR1_TS_DONE_EN
    logic         ts_done, ts_done2;
    logic [W-1:0] cur_ts, cur_ts2;
`endif

    layer1_seq_ctrl #(
        .WIDTH(W), .TIMESTEP(TS), .LAYR1_INPUT(IN), .LAYR1_CELL(CELL), .ACT_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .acc_x_1(acc_x_1), .acc_h_1(acc_h_1), .addr_x1(addr_x1),
        .rd_addr_w_1(rd_addr_w_1), .rd_addr_u_1(rd_addr_u_1), .rd_addr_b_1(rd_addr_b_1),
        .rd_addr_h1(rd_addr_h1), .rd_addr_c1(rd_addr_c1), .wr_h1(wr_h1), .wr_c1(wr_c1),
        .wr_addr_h1(wr_addr_h1),
`ifdef LAYR1_TS_DONE_EN
        .ts_done(ts_done), .cur_ts(cur_ts),
`endif
        .wr_addr_c1(wr_addr_c1)
    );

    layer1_seq_ctrl #(
        .WIDTH(12), .TIMESTEP(1), .LAYR1_INPUT(53), .LAYR1_CELL(53), .ACT_LAT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .acc_x_1(acc_x2), .acc_h_1(acc_h2), .addr_x1(addr_x2),
        .rd_addr_w_1(rd_addr_w2), .rd_addr_u_1(rd_addr_u2), .rd_addr_b_1(rd_addr_b2),
        .rd_addr_h1(rd_addr_h2), .rd_addr_c1(rd_addr_c2), .wr_h1(wr_h2), .wr_c1(wr_c2),
        .wr_addr_h1(wr_addr_h2),
`ifdef LAYR1_TS_DONE_EN
        .ts_done(ts_done2), .cur_ts(cur_ts2),
`endif
        .wr_addr_c1(wr_addr_c2)
    );

    // One expected cycle of a run
    typedef struct {
        bit busy, done, acc_x, acc_h, wr, ts;
        int ax, aw, ab, ah, au, wa, rc, wn, wt, ts_t;
    } cyc_t;

    cyc_t trace[$];
    int   hold_h = 0;
    int   hold_u = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".acc_x"}, 32'(acc_x_1), 0);
        check({tag, ".acc_h"}, 32'(acc_h_1), 0);
        check({tag, ".wr_h"}, 32'(wr_h1), 0);
        check({tag, ".wr_c"}, 32'(wr_c1), 0);
    endtask

    // Expected run straight from the loop nest: t outer, n middle, k inner, then WAIT, WRITE, DONE
    task automatic build_trace();
        cyc_t c;
        trace.delete();
        for (int t = 0; t < TS; t++) begin
            for (int n = 0; n < CELL; n++) begin
                for (int k = 0; k < IN; k++) begin
                    c = '{default: 0};
                    c.busy = 1; c.acc_x = 1;
                    c.ax = t * IN + k; c.aw = n * IN + k; c.ab = n;
                    if (t > 0 && k < CELL) begin
                        c.acc_h = 1;
                        hold_h = (t - 1) * CELL + k;
                        hold_u = n * CELL + k;
                    end
                    c.ah = hold_h; c.au = hold_u;
                    trace.push_back(c);
                end
                for (int l = 0; l < LAT; l++) begin
                    c = '{default: 0};
                    c.busy = 1; c.ah = hold_h; c.au = hold_u;
                    trace.push_back(c);
                end
                c = '{default: 0};
                c.busy = 1; c.wr = 1; c.ah = hold_h; c.au = hold_u;
                c.wa = t * CELL + n;
                c.rc = (t > 0) ? (t - 1) * CELL + n : 0;
                c.wn = n; c.wt = t;
                trace.push_back(c);
            end
        end
        c = '{default: 0};
        c.done = 1; c.ah = hold_h; c.au = hold_u;
        trace.push_back(c);
        for (int i = 1; i < trace.size(); i++) begin
            if (trace[i-1].wr && trace[i-1].wn == CELL - 1) begin
                trace[i].ts = 1;
                trace[i].ts_t = trace[i-1].wt;
            end
        end
    endtask

    // One run from IDLE; abort_idx >= 0 pulls reset at that trace cycle
    task automatic do_run(input string tag, input int abort_idx);
        int gap, writes, busy_cnt;
        gap = $urandom_range(1, 4);
        writes = 0;
        busy_cnt = 0;
        build_trace();
        repeat (gap) begin
            @(negedge clk);
            start = 1'b0;
            check_idle({tag, ".pre"});
        end
        start = 1'b1;
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clk);
            if (i == abort_idx) begin
                #1 rst = 1'b0;
                start = 1'b0;
                #1;
                check({tag, ".rst.busy"}, 32'(busy), 0);
                check({tag, ".rst.acc_x"}, 32'(acc_x_1), 0);
                check({tag, ".rst.acc_h"}, 32'(acc_h_1), 0);
                check({tag, ".rst.addr_x"}, 32'(addr_x1), 0);
                check({tag, ".rst.addr_w"}, 32'(rd_addr_w_1), 0);
                check({tag, ".rst.addr_u"}, 32'(rd_addr_u_1), 0);
                check({tag, ".rst.addr_b"}, 32'(rd_addr_b_1), 0);
                check({tag, ".rst.addr_h"}, 32'(rd_addr_h1), 0);
                check({tag, ".rst.addr_c"}, 32'(rd_addr_c1), 0);
                check({tag, ".rst.wa_h"}, 32'(wr_addr_h1), 0);
                check({tag, ".rst.wa_c"}, 32'(wr_addr_c1), 0);
                hold_h = 0;
                hold_u = 0;
                @(negedge clk);
                rst = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check_idle({tag, ".post_rst"});
                end
                return;
            end
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(trace[i].busy));
            check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(trace[i].done));
            check($sformatf("%s[%0d].acc_x", tag, i), 32'(acc_x_1), 32'(trace[i].acc_x));
            check($sformatf("%s[%0d].acc_h", tag, i), 32'(acc_h_1), 32'(trace[i].acc_h));
            check($sformatf("%s[%0d].wr_h", tag, i), 32'(wr_h1), 32'(trace[i].wr));
            check($sformatf("%s[%0d].wr_c", tag, i), 32'(wr_c1), 32'(wr_h1));
            check($sformatf("%s[%0d].addr_h", tag, i), 32'(rd_addr_h1), 32'(trace[i].ah));
            check($sformatf("%s[%0d].addr_u", tag, i), 32'(rd_addr_u_1), 32'(trace[i].au));
            if (trace[i].acc_x) begin
                check($sformatf("%s[%0d].addr_x", tag, i), 32'(addr_x1), 32'(trace[i].ax));
                check($sformatf("%s[%0d].addr_w", tag, i), 32'(rd_addr_w_1), 32'(trace[i].aw));
                check($sformatf("%s[%0d].addr_b", tag, i), 32'(rd_addr_b_1), 32'(trace[i].ab));
            end
            if (trace[i].wr) begin
                check($sformatf("%s[%0d].wa_h", tag, i), 32'(wr_addr_h1), 32'(trace[i].wa));
                check($sformatf("%s[%0d].wa_c", tag, i), 32'(wr_addr_c1), 32'(trace[i].wa));
                check($sformatf("%s[%0d].addr_c", tag, i), 32'(rd_addr_c1), 32'(trace[i].rc));
            end
`ifdef LAYR1_TS_DONE_EN
            check($sformatf("%s[%0d].ts_done", tag, i), 32'(ts_done), 32'(trace[i].ts));
            if (trace[i].ts)
                check($sformatf("%s[%0d].cur_ts", tag, i), 32'(cur_ts), 32'(trace[i].ts_t));
`endif
            if (wr_h1) writes++;
            if (busy) busy_cnt++;
            // start during the run (including DONE) must have no effect
            start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        check_idle({tag, ".after_done"});
        @(negedge clk);
        check_idle({tag, ".idle2"});
        check({tag, ".write_count"}, 32'(writes), 32'(TS * CELL));
        check({tag, ".busy_count"}, 32'(busy_cnt), 32'(TS * CELL * (IN + LAT + 1)));
    endtask

    initial begin
        int abort_idx;
        int b2, d2, ax2, ah2, w2, wc_bad, last_wa, last_wc, last_rc, last_ax, last_aw, last_ab;
        int ts2;
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        #1;
        check_idle("reset");
        check("reset.addr_x", 32'(addr_x1), 0);
        check("reset.wa_h", 32'(wr_addr_h1), 0);
        check("reset.addr_h", 32'(rd_addr_h1), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_run("run1", -1);
        do_run("run2", -1);
        abort_idx = CELL * (IN + LAT + 1) + int'($urandom_range(0, CELL - 1)) * (IN + LAT + 1)
                  + int'($urandom_range(0, IN - 1));
        do_run("abort", abort_idx);
        do_run("replay", -1);

        // Default geometry, single timestep
        b2 = 0; d2 = 0; ax2 = 0; ah2 = 0; w2 = 0; wc_bad = 0; ts2 = 0;
        last_wa = -1; last_wc = -1; last_rc = -1; last_ax = -1; last_aw = -1; last_ab = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            if (busy2) b2++;
            if (done2) d2++;
            if (acc_h2) ah2++;
            if (wr_c2 !== wr_h2) wc_bad++;
            if (acc_x2) begin
                ax2++;
                last_ax = int'(addr_x2); last_aw = int'(rd_addr_w2); last_ab = int'(rd_addr_b2);
            end
            if (wr_h2) begin
                w2++;
                last_wa = int'(wr_addr_h2); last_wc = int'(wr_addr_c2); last_rc = int'(rd_addr_c2);
            end
`ifdef LAYR1_TS_DONE_EN
            if (ts_done2) begin
                ts2++;
                check("def.cur_ts", 32'(cur_ts2), 0);
            end
`endif
            @(negedge clk);
        end
        check("def.busy_cycles", 32'(b2), 2968);
        check("def.done_count", 32'(d2), 1);
        check("def.acc_x_count", 32'(ax2), 2809);
        check("def.acc_h_count", 32'(ah2), 0);
        check("def.write_count", 32'(w2), 53);
        check("def.wr_c_eq_wr_h", 32'(wc_bad), 0);
        check("def.last_addr_x", 32'(last_ax), 52);
        check("def.last_addr_w", 32'(last_aw), 2808);
        check("def.last_addr_b", 32'(last_ab), 52);
        check("def.last_wa_h", 32'(last_wa), 52);
        check("def.last_wa_c", 32'(last_wc), 52);
        check("def.last_addr_c", 32'(last_rc), 0);
        check("def.addr_h_held", 32'(rd_addr_h2), 0);
        check("def.addr_u_held", 32'(rd_addr_u2), 0);
`ifdef LAYR1_TS_DONE_EN
        check("def.ts_done_count", 32'(ts2), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer1_seq_ctrl.md
LAYER1_SEQ_CTRL -- requirements
Module: layer1_seq_ctrl

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- WIDTH 12: address width.
- TIMESTEP 7: timesteps per run.
- LAYR1_INPUT 53: x elements per timestep, which is also the ACC length.
- LAYR1_CELL 53: cells per timestep; must be <= LAYR1_INPUT.
- ACT_LAT 2: cycles from last accumulate to write-valid; must be >= 1.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.
- acc_x_1  out  1  accumulate W*x.
- acc_h_1  out  1  accumulate U*h.
- addr_x1  out  WIDTH  x read address.
- rd_addr_w_1  out  WIDTH  W read address.
- rd_addr_u_1  out  WIDTH  U read address.
- rd_addr_b_1  out  WIDTH  bias read address.
- rd_addr_h1  out  WIDTH  previous-h read address.
- rd_addr_c1  out  WIDTH  previous-c read address.
- wr_h1  out  1  h write enable.
- wr_c1  out  1  c write enable.
- wr_addr_h1  out  WIDTH  h write address.
- wr_addr_c1  out  WIDTH  c write address.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have states IDLE, ACC, WAIT, WRITE, DONE.
REQ-005 IDLE: when start=1 is sampled, the FSM SHALL go to ACC next cycle with t=0, n=0, k=0; start SHALL be ignored in any other state.
REQ-006 ACC SHALL last exactly LAYR1_INPUT cycles (k=0..LAYR1_INPUT-1), with:
- acc_x_1=1.
- addr_x1=t*LAYR1_INPUT+k.
- rd_addr_w_1=n*LAYR1_INPUT+k.
- rd_addr_b_1=n.
REQ-007 In ACC, acc_h_1=1 only when t>0 and k<LAYR1_CELL, with rd_addr_h1=(t-1)*LAYR1_CELL+k and rd_addr_u_1=n*LAYR1_CELL+k; otherwise acc_h_1=0 and the h/u addresses hold.
REQ-008 WAIT SHALL last ACT_LAT cycles with acc_x_1=acc_h_1=0 and wr_h1=wr_c1=0.
REQ-009 WRITE SHALL last 1 cycle with:
- wr_h1=wr_c1=1.
- wr_addr_h1=wr_addr_c1=t*LAYR1_CELL+n.
- rd_addr_c1=(t-1)*LAYR1_CELL+n when t>0, else 0.
REQ-010 In WRITE the FSM SHALL advance as follows:
- n<LAYR1_CELL-1: n+1, go to ACC.
- else, t<TIMESTEP-1: n=0, t+1, go to ACC.
- else: go to DONE.
REQ-011 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE; start in DONE SHALL be ignored.
REQ-012 busy SHALL be 1 in ACC, WAIT and WRITE only; busy cycles per run = TIMESTEP*LAYR1_CELL*(LAYR1_INPUT+ACT_LAT+1).
REQ-013 Write enables SHALL be zero outside WRITE, and acc_* SHALL be zero outside ACC.
REQ-014 Addresses SHALL be generated by incrementing counters with no multipliers; results SHALL be truncated to WIDTH and no wrap SHALL occur for the defaults.

Reset
REQ-015 rst=0 SHALL, asynchronously and at any point including mid-run, force IDLE, t=n=k=0, and every output to 0.
REQ-016 After reset release, no write SHALL occur until a new start.

Configuration
REQ-017 With LAYR1_TS_DONE_EN defined, the block SHALL add these ports, both 0 on reset:
- ts_done (out, 1): pulses in the cycle after the WRITE of cell LAYR1_CELL-1 of each timestep, including the last.
- cur_ts (out, WIDTH): current t.
REQ-018 Without LAYR1_TS_DONE_EN, those ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-019 The FSM state enum and default geometry constants SHALL live in a shared package lstm_ctrl_pkg.
REQ-020 The k/n/t nested counter SHALL be a sub-module nest_cnt, with per-level terminal counts and a wrap flag per level.

Verification
All scenarios use LAYR1_INPUT=3, LAYR1_CELL=2, TIMESTEP=2, ACT_LAT=2 unless stated.
REQ-021 Start pulse: busy=1 for 24 cycles, then done=1 for 1 cycle.
REQ-022 Write sequence: the four WRITE cycles carry wr_addr_h1=0,1,2,3 in that order; wr_c1 equals wr_h1 every cycle.
REQ-023 Timestep 0: acc_h_1 stays 0. Timestep 1, cell 1: rd_addr_h1=0,1 and rd_addr_u_1=2,3 while acc_h_1=1, with acc_h_1=0 on k=2; addr_x1=3,4,5 and rd_addr_w_1=3,4,5.
REQ-024 Second start asserted during busy: it is ignored and the total write count stays 4.
REQ-025 rst=0 asserted mid-ACC at t=1: all outputs go to 0 immediately; a new start replays from address 0.
REQ-026 With LAYR1_TS_DONE_EN: ts_done pulses twice, with cur_ts=0 then 1. With TIMESTEP=1 and defaults: 2968 busy cycles and a single done.
